// File: rtl/render_pkg.sv
// Shared types and defaults for the tile/sprite blitter.
package render_pkg;

    localparam int COLOR_W  = 16;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int ADDR_W   = 19;
    localparam logic [COLOR_W-1:0] KEY = 16'hF81F;

    // Screen coordinates are one bit wider than the 10-bit origin so that
    // origin + tile offset never wraps back onto the visible area.
    typedef logic [10:0] coord_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    // One in-flight pixel travelling alongside its ROM read.
    typedef struct packed {
        logic   valid;
        logic   clip;
        coord_t x;
        coord_t y;
    } pix_t;

    // Linear frame-buffer address of screen pixel (x, y).
    function automatic logic [31:0] fb_addr(input coord_t x, input coord_t y,
                                            input int unsigned width = SCREEN_W);
        return 32'(y) * width + 32'(x);
    endfunction

endpackage

// File: rtl/tile_pixel_map.sv
// Combinational mapping of a tile issue position to its ROM address and
// screen coordinate, with optional mirroring and off-screen detection.
module tile_pixel_map #(
    parameter int TILE_W   = 32,
    parameter int TILE_H   = 32,
    parameter int SCREEN_W = render_pkg::SCREEN_W,
    parameter int SCREEN_H = render_pkg::SCREEN_H,
    parameter int ADDR_W   = render_pkg::ADDR_W
) (
    input  logic [$clog2(TILE_H)-1:0] row,
    input  logic [$clog2(TILE_W)-1:0] col,
    input  logic                      flip_x,
    input  logic                      flip_y,
    input  logic [ADDR_W-1:0]         base,
    input  logic [9:0]                top,
    input  logic [9:0]                left,
    output logic [ADDR_W-1:0]         src_addr,
    output logic [10:0]               x,
    output logic [10:0]               y,
    output logic                      clip
);
    import render_pkg::*;

    localparam int     CW    = $clog2(TILE_W);
    localparam int     RW    = $clog2(TILE_H);
    localparam coord_t X_LIM = coord_t'(SCREEN_W);
    localparam coord_t Y_LIM = coord_t'(SCREEN_H);

    logic [CW-1:0] c;
    logic [RW-1:0] r;

    // Source address follows the mirrored position; screen position does not.
    always_comb begin
        // Tile sizes are powers of two, so N-1-i is simply the bitwise inverse.
        c        = flip_x ? ~col : col;
        r        = flip_y ? ~row : row;
        // r*TILE_W + c is the concatenation {r, c} for power-of-two widths.
        src_addr = base + ADDR_W'({r, c});
        x        = coord_t'(left) + coord_t'(col);
        y        = coord_t'(top) + coord_t'(row);
        clip     = (x >= X_LIM) || (y >= Y_LIM);
    end

endmodule

// File: rtl/render_sprite.sv
// Tile blitter: copies one TILE_W x TILE_H tile from clock-enabled ROM into
// the frame buffer with flip, colour-key, clipping and write back-pressure.
module render_sprite #(
    parameter int TILE_W   = 32,
    parameter int TILE_H   = 32,
    parameter int SCREEN_W = render_pkg::SCREEN_W,
    parameter int SCREEN_H = render_pkg::SCREEN_H,
    parameter int ADDR_W   = render_pkg::ADDR_W,
    parameter int COLOR_W  = render_pkg::COLOR_W,
    parameter int ROM_LAT  = 1,
    parameter logic [COLOR_W-1:0] KEY = render_pkg::KEY
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [ADDR_W-1:0]  tile_addr,
    input  logic [9:0]         top,
    input  logic [9:0]         left,
    input  logic               flip_x,
    input  logic               flip_y,
    input  logic               key_en,
    output logic               busy,
    output logic               done,
    output logic               src_en,
    output logic [ADDR_W-1:0]  src_addr,
    input  logic [COLOR_W-1:0] src_data,
    output logic [ADDR_W-1:0]  dst_addr,
    output logic [COLOR_W-1:0] dst_data,
    output logic               dst_wr,
    input  logic               dst_ready
);
    import render_pkg::*;

    localparam int CW    = $clog2(TILE_W);
    localparam int RW    = $clog2(TILE_H);
    localparam int CNT_W = RW + CW;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;          // {row, col}, col fastest
    logic [ADDR_W-1:0]    tile_addr_q, tile_addr_d;
    logic [9:0]           top_q, top_d, left_q, left_d;
    logic                 flip_x_q, flip_x_d, flip_y_q, flip_y_d, key_en_q, key_en_d;
    pix_t [ROM_LAT-1:0]   pipe_q, pipe_d;
    logic                 dst_wr_q, dst_wr_d;
    logic [ADDR_W-1:0]    dst_addr_q, dst_addr_d;
    logic [COLOR_W-1:0]   dst_data_q, dst_data_d;

    logic                 stall, pipe_empty, keyed, load;
    logic [ADDR_W-1:0]    map_addr;
    coord_t               map_x, map_y;
    logic                 map_clip;
    pix_t                 tail;

    tile_pixel_map #(
        .TILE_W   (TILE_W),
        .TILE_H   (TILE_H),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .ADDR_W   (ADDR_W)
    ) u_map (
        .row      (cnt_q[CNT_W-1:CW]),
        .col      (cnt_q[CW-1:0]),
        .flip_x   (flip_x_q),
        .flip_y   (flip_y_q),
        .base     (tile_addr_q),
        .top      (top_q),
        .left     (left_q),
        .src_addr (map_addr),
        .x        (map_x),
        .y        (map_y),
        .clip     (map_clip)
    );

    // A pending write that the frame buffer refuses freezes the whole datapath.
    assign stall = dst_wr_q & ~dst_ready;
    assign tail  = pipe_q[ROM_LAT-1];

    // FSM next state, issue counter and start-time latching of the job.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        tile_addr_d = tile_addr_q;
        top_d       = top_q;
        left_d      = left_q;
        flip_x_d    = flip_x_q;
        flip_y_d    = flip_y_q;
        key_en_d    = key_en_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = ISSUE;
                    cnt_d       = '0;
                    tile_addr_d = tile_addr;
                    top_d       = top;
                    left_d      = left;
                    flip_x_d    = flip_x;
                    flip_y_d    = flip_y;
                    key_en_d    = key_en;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (&cnt_q) state_d = DRAIN;
                end
            end
            DRAIN:   if (pipe_empty && !dst_wr_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latency pipe: carries pixel position alongside the outstanding ROM read.
    always_comb begin
        pipe_d = pipe_q;
        if (!stall) begin
            pipe_d[0].valid = (state_q == ISSUE);
            pipe_d[0].clip  = map_clip;
            pipe_d[0].x     = map_x;
            pipe_d[0].y     = map_y;
            for (int i = 1; i < ROM_LAT; i++) pipe_d[i] = pipe_q[i-1];
        end
    end

    // Drain detection: no pixel left waiting on the ROM.
    always_comb begin
        pipe_empty = 1'b1;
        for (int i = 0; i < ROM_LAT; i++) begin
            if (pipe_q[i].valid) pipe_empty = 1'b0;
        end
    end

    // Output stage: only visible, non-transparent pixels become writes.
    always_comb begin
        keyed      = key_en_q && (src_data == KEY);
        load       = !stall && tail.valid && !tail.clip && !keyed;
        dst_wr_d   = stall | load;
        dst_addr_d = load ? ADDR_W'(fb_addr(tail.x, tail.y, SCREEN_W)) : dst_addr_q;
        dst_data_d = load ? src_data : dst_data_q;
    end

    // State registers; reset drops any job and any pending write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tile_addr_q <= '0;
            top_q       <= '0;
            left_q      <= '0;
            flip_x_q    <= 1'b0;
            flip_y_q    <= 1'b0;
            key_en_q    <= 1'b0;
            pipe_q      <= '0;
            dst_wr_q    <= 1'b0;
            dst_addr_q  <= '0;
            dst_data_q  <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tile_addr_q <= tile_addr_d;
            top_q       <= top_d;
            left_q      <= left_d;
            flip_x_q    <= flip_x_d;
            flip_y_q    <= flip_y_d;
            key_en_q    <= key_en_d;
            pipe_q      <= pipe_d;
            dst_wr_q    <= dst_wr_d;
            dst_addr_q  <= dst_addr_d;
            dst_data_q  <= dst_data_d;
        end
    end

    assign busy     = (state_q == ISSUE) || (state_q == DRAIN);
    assign done     = (state_q == DONE);
    assign src_en   = ~stall;
    assign src_addr = map_addr;
    assign dst_wr   = dst_wr_q;
    assign dst_addr = dst_addr_q;
    assign dst_data = dst_data_q;

endmodule

// File: tb/tb_render_sprite.sv
// Scoreboard bench for render_sprite: expected writes are queued when a tile
// is started; a negedge monitor pops and compares each accepted write.
module tb_render_sprite;

    typedef struct {
        logic [18:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        clk, rstn, start;
    logic [18:0] tile_addr;
    logic [9:0]  top, left;
    logic        flip_x, flip_y, key_en;
    logic        busy, done, src_en;
    logic [18:0] src_addr;
    logic [15:0] src_data;
    logic [18:0] dst_addr;
    logic [15:0] dst_data;
    logic        dst_wr, dst_ready;

    logic [15:0] rom [4096];
    wr_t         exp_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          n_wr  = 0;
    bit          bp_mode = 0;

    render_sprite dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .tile_addr (tile_addr),
        .top       (top),
        .left      (left),
        .flip_x    (flip_x),
        .flip_y    (flip_y),
        .key_en    (key_en),
        .busy      (busy),
        .done      (done),
        .src_en    (src_en),
        .src_addr  (src_addr),
        .src_data  (src_data),
        .dst_addr  (dst_addr),
        .dst_data  (dst_data),
        .dst_wr    (dst_wr),
        .dst_ready (dst_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Clock-enabled single-cycle ROM.
    initial src_data = '0;
    always @(posedge clk) if (src_en) src_data <= rom[src_addr[11:0]];

    // Frame-buffer ready: always high, or a coin toss per cycle.
    initial begin
        dst_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            dst_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted write must match the head of the queue, and a
    // refused write must hold its address and data into the next cycle.
    initial begin
        bit          stalled = 0;
        logic [18:0] h_addr  = '0;
        logic [15:0] h_data  = '0;
        wr_t         w;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                stalled = 0;
            end else begin
                if (stalled) begin
                    check("hold_wr", 32'(dst_wr), 1);
                    check("hold_addr", 32'(dst_addr), 32'(h_addr));
                    check("hold_data", 32'(dst_data), 32'(h_data));
                end
                if (dst_wr && dst_ready) begin
                    n_wr++;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_write: got addr %0d data %h, want no write",
                                 dst_addr, dst_data);
                    end else begin
                        w = exp_q.pop_front();
                        check("wr_addr", 32'(dst_addr), 32'(w.addr));
                        check("wr_data", 32'(dst_data), 32'(w.data));
                    end
                end
                stalled = dst_wr && !dst_ready;
                h_addr  = dst_addr;
                h_data  = dst_data;
            end
        end
    end

    // 0: ROM[i]=i   1: ROM[i]=7i+3   2: even words are the colour key, odd words ROM[i]=i
    task automatic fill_rom(input int mode);
        for (int i = 0; i < 4096; i++) begin
            case (mode)
                1:       rom[i] = 16'(i * 7 + 3);
                2:       rom[i] = (i % 2 == 0) ? 16'hF81F : 16'(i);
                default: rom[i] = 16'(i);
            endcase
        end
    endtask

    // Reference model: expected writes of one tile in issue order.
    task automatic push_expected(input logic [18:0] ta, input int t, input int l,
                                 input logic fx, input logic fy, input logic ke);
        for (int row = 0; row < 32; row++) begin
            for (int col = 0; col < 32; col++) begin
                int  x, y, r, c;
                wr_t w;
                x = l + col;
                y = t + row;
                if (x < 640 && y < 480) begin
                    r = fy ? 31 - row : row;
                    c = fx ? 31 - col : col;
                    w.data = rom[(int'(ta) + r * 32 + c) % 4096];
                    w.addr = 19'(y * 640 + x);
                    if (!(ke && w.data == 16'hF81F)) exp_q.push_back(w);
                end
            end
        end
    endtask

    task automatic start_tile(input logic [18:0] ta, input int t, input int l,
                              input logic fx, input logic fy, input logic ke);
        @(negedge clk);
        tile_addr = ta;
        top       = 10'(t);
        left      = 10'(l);
        flip_x    = fx;
        flip_y    = fy;
        key_en    = ke;
        start     = 1'b1;
    endtask

    // Render one tile and check the run as a whole. poke_cyc>1 pulses start
    // with other inputs while busy; poke_done pulses start during done.
    task automatic run_tile(input string name, input logic [18:0] ta, input int t, input int l,
                            input logic fx, input logic fy, input logic ke,
                            input int exp_writes, input bit timing,
                            input int poke_cyc, input bit poke_done);
        int cyc, busy_cyc, first_wr;
        bit finished;
        cyc = 0; busy_cyc = 0; first_wr = 0; finished = 0;
        n_wr = 0;
        push_expected(ta, t, l, fx, fy, ke);
        start_tile(ta, t, l, fx, fy, ke);
        while (!finished && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1 || cyc == poke_cyc + 1) start = 1'b0;
            if (cyc == poke_cyc) begin
                start = 1'b1; tile_addr = 19'h123; top = 10'd7; left = 10'd9;
                flip_x = ~fx; flip_y = ~fy; key_en = ~ke;
            end
            if (busy) busy_cyc++;
            if (dst_wr && first_wr == 0) first_wr = cyc;
            if (done) finished = 1;
        end
        check({name, ":done_seen"}, 32'(finished), 1);
        if (poke_done) begin
            start = 1'b1; tile_addr = 19'h321; flip_x = ~fx;
        end
        @(negedge clk);
        start = 1'b0;
        check({name, ":done_one_cycle"}, 32'(done), 0);
        check({name, ":idle_after_done"}, 32'(busy), 0);
        check({name, ":writes"}, 32'(n_wr), 32'(exp_writes));
        check({name, ":queue_left"}, 32'(exp_q.size()), 0);
        if (timing) begin
            check({name, ":busy_cycles"}, 32'(busy_cyc), 1027);
            check({name, ":first_write_cycle"}, 32'(first_wr), 3);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int k;
        rstn = 1'b0; start = 1'b0; tile_addr = '0; top = '0; left = '0;
        flip_x = 1'b0; flip_y = 1'b0; key_en = 1'b0;
        fill_rom(0);
        repeat (3) @(negedge clk);
        check("rst:busy", 32'(busy), 0);
        check("rst:done", 32'(done), 0);
        check("rst:dst_wr", 32'(dst_wr), 0);
        check("rst:src_en", 32'(src_en), 1);
        check("rst:src_addr", 32'(src_addr), 0);
        check("rst:dst_addr", 32'(dst_addr), 0);
        check("rst:dst_data", 32'(dst_data), 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        fill_rom(0);
        run_tile("plain", 19'd0, 0, 0, 0, 0, 0, 1024, 1, 0, 0);
        fill_rom(1);
        run_tile("flip_xy", 19'd0, 0, 0, 1, 1, 0, 1024, 0, 0, 0);
        run_tile("offset", 19'd1024, 100, 200, 0, 0, 0, 1024, 0, 0, 0);
        run_tile("clip", 19'd0, 470, 620, 0, 0, 0, 200, 0, 0, 0);
        run_tile("all_clipped", 19'd0, 0, 640, 0, 0, 0, 0, 0, 0, 0);
        fill_rom(2);
        run_tile("key_on", 19'd0, 0, 0, 0, 0, 1, 512, 0, 0, 0);
        run_tile("key_off", 19'd0, 0, 0, 0, 0, 0, 1024, 0, 0, 0);

        fill_rom(0);
        bp_mode = 1;
        run_tile("backpressure", 19'd0, 0, 0, 0, 0, 0, 1024, 0, 0, 0);
        bp_mode = 0;
        repeat (2) @(negedge clk);
        run_tile("start_ignored", 19'd0, 0, 0, 0, 0, 0, 1024, 1, 100, 1);

        // Reset in the middle of a tile, then a clean full tile.
        n_wr = 0;
        push_expected(19'd0, 0, 0, 0, 0, 0);
        start_tile(19'd0, 0, 0, 0, 0, 0);
        k = 0;
        while (n_wr < 300 && k < 5000) begin
            @(negedge clk);
            k++;
            if (k == 1) start = 1'b0;
        end
        check("midrst:reached_300", 32'(n_wr >= 300), 1);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("midrst:busy", 32'(busy), 0);
        check("midrst:dst_wr", 32'(dst_wr), 0);
        check("midrst:done", 32'(done), 0);
        check("midrst:src_en", 32'(src_en), 1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        run_tile("after_reset", 19'd0, 0, 0, 0, 0, 0, 1024, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
